// File: rtl/mult_arb_if.sv
// Request/grant/result bundle for mult_arb_seq.
// The master side (requesters) drives the requests and operands.
// The slave side (the multiplier) drives the grants, done pulses, product and busy.
interface mult_arb_if;
    logic       req0;
    logic [3:0] x0;
    logic [3:0] y0;
    logic       req1;
    logic [3:0] x1;
    logic [3:0] y1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [7:0] pro;
    logic       busy;

    modport master (
        output req0, x0, y0, req1, x1, y1,
        input  gnt0, gnt1, done0, done1, pro, busy
    );

    modport slave (
        input  req0, x0, y0, req1, x1, y1,
        output gnt0, gnt1, done0, done1, pro, busy
    );
endinterface

// File: rtl/mult_arb_seq.sv
// Two-requester arbitrated 4x4 unsigned shift-add multiplier.
//
// Build option MULT_RR_ARB_EN:
//   defined   - round-robin arbitration; a "last served" pointer picks the winner
//               when both requesters ask at the same time.
//   undefined - fixed priority; requester 0 always wins and no pointer exists.
//
// Timeline from an accept edge E0:
//   - gnt is high in the cycle after E0.
//   - E1..E4 are the four iterations.
//   - done is high in the cycle after E4 (the DONE state).
//   - The FSM returns to IDLE at E5, so the earliest next accept is at E6.
//
// States:
//   IDLE | waiting for a request; the only state in which requests are sampled
//   RUN  | one shift-add iteration per clock, four in total
//   DONE | product registered, done pulse of the owner is high
module mult_arb_seq (
    input logic       clk,
    input logic       rst,
    mult_arb_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] acc;
    logic [3:0] q;
    logic [3:0] b;
    logic [1:0] cnt;
    logic       owner;

    logic       gnt0_r;
    logic       gnt1_r;
    logic       done0_r;
    logic       done1_r;
    logic [7:0] pro_r;
    logic       busy_r;

    logic       win0;
    logic       win1;
    logic       accept;
    logic [4:0] sum;
    logic [3:0] acc_nx;
    logic [3:0] q_nx;

`ifdef MULT_RR_ARB_EN
    // last = 1 means requester 1 was served most recently.
    logic last;

    // Round-robin winner select: on a tie, the requester not served last wins.
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (bus.req0 && bus.req1) begin
            win0 = last;
            win1 = ~last;
        end else begin
            win0 = bus.req0;
            win1 = bus.req1;
        end
    end

    // Pointer records the winner of every accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= win1;
        end
    end
`else
    // Fixed priority winner select: requester 0 always beats requester 1.
    always_comb begin
        win0 = bus.req0;
        win1 = bus.req1 & ~bus.req0;
    end
`endif

    assign accept = (state == IDLE) && (win0 || win1);

    // One shift-add step: the 5-bit sum keeps the carry, then {carry,acc,q} >> 1.
    always_comb begin
        sum    = {1'b0, acc} + (q[0] ? {1'b0, b} : 5'd0);
        acc_nx = sum[4:1];
        q_nx   = {sum[0], q[3:1]};
    end

    // Sequencer FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= 4'd0;
            q       <= 4'd0;
            b       <= 4'd0;
            cnt     <= 2'd0;
            owner   <= 1'b0;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            pro_r   <= 8'h00;
            busy_r  <= 1'b0;
        end else begin
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        b      <= win0 ? bus.x0 : bus.x1;
                        q      <= win0 ? bus.y0 : bus.y1;
                        acc    <= 4'd0;
                        cnt    <= 2'd0;
                        owner  <= win1;
                        gnt0_r <= win0;
                        gnt1_r <= win1;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    q   <= q_nx;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        pro_r   <= {acc_nx, q_nx};
                        done0_r <= ~owner;
                        done1_r <= owner;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0  = gnt0_r;
    assign bus.gnt1  = gnt1_r;
    assign bus.done0 = done0_r;
    assign bus.done1 = done1_r;
    assign bus.pro   = pro_r;
    assign bus.busy  = busy_r;

endmodule

// File: tb/tb_mult_arb_seq.sv
// Directed bench for mult_arb_seq: a vector table of single transactions plus
// hand-written sequences for arbitration, abort and ignored requests.
// Expected values follow whichever arbitration build (MULT_RR_ARB_EN) is compiled.
module tb_mult_arb_seq;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mult_arb_if bus ();

    mult_arb_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r0;
        logic [3:0] x0;
        logic [3:0] y0;
        logic       r1;
        logic [3:0] x1;
        logic [3:0] y1;
        int         sel;
        logic [7:0] pro;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Follows one transaction whose request is already applied, starting just
    // after a posedge with the DUT in IDLE; ends 1 time unit after E5.
    task automatic txn_check(input int sel, input logic [7:0] exp_pro, input bit drop);
        @(posedge clk); #1;
        chk("gnt_winner", sel == 0 ? bus.gnt0 : bus.gnt1, 8'd1);
        chk("gnt_other",  sel == 0 ? bus.gnt1 : bus.gnt0, 8'd0);
        chk("busy_e0",    bus.busy, 8'd1);
        if (drop) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
            bus.x0 = ~bus.x0;
            bus.y0 = ~bus.y0;
            bus.x1 = ~bus.x1;
            bus.y1 = ~bus.y1;
        end
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            chk("done_early", {7'd0, bus.done0 | bus.done1}, 8'd0);
            chk("gnt_long",   {7'd0, bus.gnt0 | bus.gnt1}, 8'd0);
        end
        @(posedge clk); #1;
        chk("done_winner", sel == 0 ? bus.done0 : bus.done1, 8'd1);
        chk("done_other",  sel == 0 ? bus.done1 : bus.done0, 8'd0);
        chk("pro",         bus.pro, exp_pro);
        chk("busy_done",   bus.busy, 8'd1);
        @(posedge clk); #1;
        chk("done_len",  {7'd0, bus.done0 | bus.done1}, 8'd0);
        chk("busy_idle", bus.busy, 8'd0);
        chk("pro_hold",  bus.pro, exp_pro);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",  {6'd0, bus.gnt0, bus.gnt1}, 8'd0);
        chk("rst_done", {6'd0, bus.done0, bus.done1}, 8'd0);
        chk("rst_busy", bus.busy, 8'd0);
        chk("rst_pro",  bus.pro, 8'h00);
        rst = 1'b0;
    endtask

    // Invariants watched on every falling edge.
    logic [7:0] prev_pro;
    logic       prev_rst;
    bit         mon_on;
    always @(negedge clk) begin
        if (mon_on) begin
            chk("gnt_excl",  {7'd0, bus.gnt0 & bus.gnt1}, 8'd0);
            chk("done_excl", {7'd0, bus.done0 & bus.done1}, 8'd0);
            if (bus.pro !== prev_pro && !rst && !prev_rst)
                chk("pro_with_done", {7'd0, bus.done0 | bus.done1}, 8'd1);
        end
        prev_pro = bus.pro;
        prev_rst = rst;
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_on   = 1'b0;
        rst      = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.x0 = 4'd0; bus.y0 = 4'd0;
        bus.x1 = 4'd0; bus.y1 = 4'd0;

        //          r0  x0     y0     r1  x1      y1      sel pro
        vecs[0] = '{1'b1, 4'd3,  4'd5,  1'b0, 4'd0,  4'd0,  0, 8'd15};
        vecs[1] = '{1'b0, 4'd0,  4'd0,  1'b1, 4'd15, 4'd15, 1, 8'd225};
        vecs[2] = '{1'b0, 4'd0,  4'd0,  1'b1, 4'd0,  4'd9,  1, 8'd0};
        vecs[3] = '{1'b1, 4'd6,  4'd4,  1'b0, 4'd0,  4'd0,  0, 8'd24};
        vecs[4] = '{1'b1, 4'd15, 4'd15, 1'b0, 4'd0,  4'd0,  0, 8'd225};
        vecs[5] = '{1'b0, 4'd0,  4'd0,  1'b1, 4'd9,  4'd11, 1, 8'd99};
        // Tie right after a requester-1 transaction: requester 0 wins in both builds.
        vecs[6] = '{1'b1, 4'd7,  4'd3,  1'b1, 4'd12, 4'd12, 0, 8'd21};

        @(posedge clk); #1;
        do_reset();
        mon_on = 1'b1;

        foreach (vecs[i]) begin
            bus.req0 = vecs[i].r0; bus.x0 = vecs[i].x0; bus.y0 = vecs[i].y0;
            bus.req1 = vecs[i].r1; bus.x1 = vecs[i].x1; bus.y1 = vecs[i].y1;
            txn_check(vecs[i].sel, vecs[i].pro, 1'b1);
        end

        // A request raised and dropped while busy is never served.
        bus.req0 = 1'b1; bus.x0 = 4'd2; bus.y0 = 4'd3;
        @(posedge clk); #1;
        chk("ghost_gnt0", {7'd0, bus.gnt0}, 8'd1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.x1 = 4'd5; bus.y1 = 4'd5;
        @(posedge clk); #1;
        bus.req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ghost_done0", {7'd0, bus.done0}, 8'd1);
        chk("ghost_pro",   bus.pro, 8'd6);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("ghost_no_gnt", {6'd0, bus.gnt0, bus.gnt1}, 8'd0);
            chk("ghost_idle",   bus.busy, 8'd0);
        end

        // Both requesters held continuously from reset.
        do_reset();
        bus.req0 = 1'b1; bus.x0 = 4'd3; bus.y0 = 4'd5;
        bus.req1 = 1'b1; bus.x1 = 4'd2; bus.y1 = 4'd7;
        for (int k = 0; k < 4; k++) begin
`ifdef MULT_RR_ARB_EN
            txn_check(k % 2, (k % 2 == 0) ? 8'd15 : 8'd14, 1'b0);
`else
            txn_check(0, 8'd15, 1'b0);
`endif
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset on the second RUN edge aborts without a done pulse.
        bus.req0 = 1'b1; bus.x0 = 4'd7; bus.y0 = 4'd7;
        @(posedge clk); #1;
        chk("abort_gnt0", {7'd0, bus.gnt0}, 8'd1);
        bus.req0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", bus.busy, 8'd0);
        chk("abort_pro",  bus.pro, 8'd0);
        chk("abort_done", {6'd0, bus.done0, bus.done1}, 8'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", {6'd0, bus.done0, bus.done1}, 8'd0);
            chk("abort_idle",    bus.busy, 8'd0);
        end
        bus.req1 = 1'b1; bus.x1 = 4'd2; bus.y1 = 4'd7;
        txn_check(1, 8'd14, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
